// File: rtl/alu_sequencer_if.sv
// Decoder-to-sequencer request handshake plus every control strobe the sequencer drives into the ALU block.
// The master side issues start/op/cnt; the slave side (the sequencer) drives status and strobes.
interface alu_sequencer_if;
  logic       start;
  logic [2:0] op;
  logic [3:0] cnt;
  logic       busy;
  logic       done;
  logic       a_outn;
  logic       b_outn;
  logic       addsub_outn;
  logic       a_loadn;
  logic       b_loadn;
  logic       alt;
  logic       calcfn;
  logic       ext_grant;

  modport master (
    output start, op, cnt,
    input  busy, done, a_outn, b_outn, addsub_outn, a_loadn, b_loadn, alt, calcfn, ext_grant
  );

  modport slave (
    input  start, op, cnt,
    output busy, done, a_outn, b_outn, addsub_outn, a_loadn, b_loadn, alt, calcfn, ext_grant
  );
endinterface

// File: rtl/alu_sequencer.sv
// Two-phase (SETUP/COMMIT) controller for the A/B + add/sub + flags datapath; op runs cnt+1 times, DONE 2(cnt+1)+1 cycles after start.
// No backpressure: start is only sampled in IDLE/DONE and silently ignored while busy; all outputs are registered.
module alu_sequencer (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave seq
);

  typedef enum logic [1:0] {IDLE, SETUP, COMMIT, DONE} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_CMP   = 3'd3;
  localparam logic [2:0] OP_MOVAB = 3'd4;
  localparam logic [2:0] OP_MOVBA = 3'd5;
  localparam logic [2:0] OP_LDA   = 3'd6;
  localparam logic [2:0] OP_LDB   = 3'd7;

  typedef struct packed {
    logic busy;
    logic done;
    logic a_outn;
    logic b_outn;
    logic addsub_outn;
    logic a_loadn;
    logic b_loadn;
    logic alt;
    logic calcfn;
    logic ext_grant;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{busy: 1'b0, done: 1'b0, a_outn: 1'b1, b_outn: 1'b1,
                                addsub_outn: 1'b1, a_loadn: 1'b1, b_loadn: 1'b1,
                                alt: 1'b0, calcfn: 1'b1, ext_grant: 1'b0};

  state_t     state_q, state_d;
  logic [3:0] iter_q, iter_d;
  logic [2:0] op_q, op_d;
  ctl_t       ctl_q, ctl_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      iter_q  <= 4'd0;
      op_q    <= OP_NOP;
      ctl_q   <= CTL_IDLE;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      op_q    <= op_d;
      ctl_q   <= ctl_d;
    end
  end

  // Strobes are precomputed from the next state and next op so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    op_d    = op_q;
    ctl_d   = CTL_IDLE;

    case (state_q)
      IDLE, DONE: begin
        if (seq.start) begin
          op_d    = seq.op;
          iter_d  = seq.cnt;
          state_d = (seq.op == OP_NOP) ? DONE : SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: state_d = COMMIT;
      COMMIT: begin
        if (iter_q == 4'd0) begin
          state_d = DONE;
        end else begin
          iter_d  = iter_q - 4'd1;
          state_d = SETUP;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      SETUP, COMMIT: begin
        ctl_d.busy = 1'b1;
        ctl_d.alt  = (op_d == OP_SUB) || (op_d == OP_CMP);
        case (op_d)
          OP_ADD, OP_SUB, OP_CMP: ctl_d.addsub_outn = 1'b0;
          OP_MOVAB:               ctl_d.a_outn      = 1'b0;
          OP_MOVBA:               ctl_d.b_outn      = 1'b0;
          OP_LDA, OP_LDB:         ctl_d.ext_grant   = 1'b1;
          default: ;
        endcase
        if (state_d == COMMIT) begin
          ctl_d.a_loadn = !((op_d == OP_ADD) || (op_d == OP_SUB) ||
                            (op_d == OP_MOVBA) || (op_d == OP_LDA));
          ctl_d.b_loadn = !((op_d == OP_MOVAB) || (op_d == OP_LDB));
          ctl_d.calcfn  = !((op_d == OP_ADD) || (op_d == OP_SUB) || (op_d == OP_CMP));
        end
      end
      DONE:    ctl_d.done = 1'b1;
      default: ;
    endcase
  end

  assign seq.busy        = ctl_q.busy;
  assign seq.done        = ctl_q.done;
  assign seq.a_outn      = ctl_q.a_outn;
  assign seq.b_outn      = ctl_q.b_outn;
  assign seq.addsub_outn = ctl_q.addsub_outn;
  assign seq.a_loadn     = ctl_q.a_loadn;
  assign seq.b_loadn     = ctl_q.b_loadn;
  assign seq.alt         = ctl_q.alt;
  assign seq.calcfn      = ctl_q.calcfn;
  assign seq.ext_grant   = ctl_q.ext_grant;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving a small behavioural A/B/adder/flags datapath from the DUT strobes.
// Control vector order: busy, done, a_outn, b_outn, addsub_outn, a_loadn, b_loadn, alt, calcfn, ext_grant.
module tb_alu_sequencer;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MOVAB = 3'd4;
  localparam logic [2:0] OP_MOVBA = 3'd5;
  localparam logic [2:0] OP_LDA   = 3'd6;
  localparam logic [2:0] OP_LDB   = 3'd7;

  localparam logic [9:0] VEC_IDLE    = 10'b0011111010;
  localparam logic [9:0] VEC_ADD_SET = 10'b1011011010;
  localparam logic [9:0] VEC_ADD_COM = 10'b1011001000;
  localparam logic [9:0] VEC_DONE    = 10'b0111111010;
  localparam logic [9:0] VEC_LDB_SET = 10'b1011111011;
  localparam logic [9:0] VEC_MBA_COM = 10'b1010101010;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if sif();
  alu_sequencer dut (.clk(clk), .reset(reset), .seq(sif));

  logic [7:0] ext_data = 8'h00;
  logic [7:0] a_reg    = 8'h00;
  logic [7:0] b_reg    = 8'h00;
  logic       c_flag   = 1'b0;
  logic [7:0] main_bus;
  logic [8:0] addsub_res;
  int         a_load_cnt = 0;
  int         bus_viol   = 0;

  always_comb begin
    addsub_res = sif.alt ? ({1'b0, a_reg} - {1'b0, b_reg}) : ({1'b0, a_reg} + {1'b0, b_reg});
    main_bus   = 8'hFF;
    if (!sif.a_outn)           main_bus = a_reg;
    else if (!sif.b_outn)      main_bus = b_reg;
    else if (!sif.addsub_outn) main_bus = addsub_res[7:0];
    else if (sif.ext_grant)    main_bus = ext_data;
  end

  always @(posedge clk) begin
    if (!sif.a_loadn) begin
      a_reg      <= main_bus;
      a_load_cnt <= a_load_cnt + 1;
    end
    if (!sif.b_loadn) b_reg  <= main_bus;
    if (!sif.calcfn)  c_flag <= addsub_res[8];
  end

  always @(negedge clk)
    if ($countones({~sif.a_outn, ~sif.b_outn, ~sif.addsub_outn, sif.ext_grant}) > 1)
      bus_viol++;

  int n_chk = 0;
  int n_fail = 0;
  int cyc, n_alt, n_calc, n_ext, done_cyc;
  bit got_done;
  int load_base;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl_vec();
    return {sif.busy, sif.done, sif.a_outn, sif.b_outn, sif.addsub_outn,
            sif.a_loadn, sif.b_loadn, sif.alt, sif.calcfn, sif.ext_grant};
  endfunction

  task automatic clear_counters();
    cyc = 0; n_alt = 0; n_calc = 0; n_ext = 0; done_cyc = 0; got_done = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (sif.alt)     n_alt++;
    if (!sif.calcfn) n_calc++;
    if (sif.ext_grant) n_ext++;
    if (sif.done && !got_done) begin
      got_done = 1'b1;
      done_cyc = cyc;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] cnt);
    sif.start = 1'b1;
    sif.op    = op;
    sif.cnt   = cnt;
    @(posedge clk);
    #1 sif.start = 1'b0;
    clear_counters();
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100 && !got_done; i++) step();
    check(tag, got_done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [3:0] cnt, input string tag);
    issue(op, cnt);
    wait_done(tag);
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ext_data = a;
    run_op(OP_LDA, 4'd0, "lda_done");
    ext_data = b;
    run_op(OP_LDB, 4'd0, "ldb_done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.start = 1'b0;
    sif.op    = OP_NOP;
    sif.cnt   = 4'd0;

    // Asynchronous reset, observed before the first clock edge.
    #1 reset = 1'b0;
    #1 check("rst_async_vec", ctl_vec(), VEC_IDLE);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD with cycle-by-cycle strobe checks.
    load_ab(8'h10, 8'h03);
    check("lda_value", a_reg, 8'h10);
    check("ldb_value", b_reg, 8'h03);
    issue(OP_ADD, 4'd0);
    step(); check("add_setup_vec", ctl_vec(), VEC_ADD_SET);
    step(); check("add_commit_vec", ctl_vec(), VEC_ADD_COM);
    step(); check("add_done_vec", ctl_vec(), VEC_DONE);
    wait_done("add_done");
    check("add_result", a_reg, 8'h13);
    check("add_carry", c_flag, 1'b0);

    // SUB repeated four times: 0x20 - 4*0x05.
    load_ab(8'h20, 8'h05);
    run_op(OP_SUB, 4'd3, "sub_done");
    check("sub_alt_cycles", n_alt, 8);
    check("sub_calcfn_pulses", n_calc, 4);
    check("sub_done_cycle", done_cyc, 9);
    check("sub_result", a_reg, 8'h0C);

    // Repeated ADD across the byte boundary.
    load_ab(8'h80, 8'h80);
    issue(OP_ADD, 4'd1);
    repeat (3) step();
    check("add2_iter0_a", a_reg, 8'h00);
    check("add2_iter0_carry", c_flag, 1'b1);
    wait_done("add2_done");
    check("add2_done_cycle", done_cyc, 5);
    check("add2_final_a", a_reg, 8'h80);
    check("add2_final_carry", c_flag, 1'b0);

    // NOP goes straight to DONE.
    run_op(OP_NOP, 4'd7, "nop_done");
    check("nop_done_cycle", done_cyc, 1);

    // start held through a MOVAB with op changed mid-flight, then LDB issued back-to-back from DONE.
    ext_data = 8'h42;
    run_op(OP_LDA, 4'd0, "lda42_done");
    sif.start = 1'b1;
    sif.op    = OP_MOVAB;
    sif.cnt   = 4'd2;
    @(posedge clk);
    #1;
    clear_counters();
    sif.op  = OP_LDA;
    sif.cnt = 4'd0;
    for (int i = 0; i < 100 && !got_done; i++) step();
    check("movab_done", got_done, 1'b1);
    check("movab_done_cycle", done_cyc, 7);
    check("movab_no_ext", n_ext, 0);
    check("movab_b", b_reg, 8'h42);
    sif.op   = OP_LDB;
    ext_data = 8'h5A;
    @(posedge clk);
    #1 sif.start = 1'b0;
    clear_counters();
    step();
    check("b2b_ldb_setup_vec", ctl_vec(), VEC_LDB_SET);
    wait_done("b2b_ldb_done");
    check("b2b_ldb_b", b_reg, 8'h5A);
    check("b2b_ldb_a_kept", a_reg, 8'h42);

    // Reset during the second iteration's COMMIT of MOVBA cnt=5.
    issue(OP_MOVBA, 4'd5);
    load_base = a_load_cnt;
    repeat (4) step();
    check("movba_commit_vec", ctl_vec(), VEC_MBA_COM);
    reset = 1'b0;
    #1 check("midop_rst_vec", ctl_vec(), VEC_IDLE);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) step();
    check("post_rst_idle_vec", ctl_vec(), VEC_IDLE);
    check("post_rst_loads", a_load_cnt - load_base, 1);
    check("post_rst_a", a_reg, 8'h5A);
    @(posedge clk);
    #1;

    // Random op/cnt/start stream for bus exclusivity.
    repeat (10000) begin
      sif.start = 1'($urandom_range(0, 1));
      sif.op    = 3'($urandom_range(0, 7));
      sif.cnt   = 4'($urandom_range(0, 15));
      ext_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    sif.start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("random_drain_idle_vec", ctl_vec(), VEC_IDLE);
    check("bus_exclusive", bus_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
